// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags, ADC/SBC and an optional
// shift-add multiplier compiled in by defining ALU_SEQ_MUL_EN.
//
// state  | meaning
// IDLE   | accepts a request whenever the output register can take a result
// MUL    | one multiplier bit per edge; result written on the last bit
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             CarryIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_LSL = 4'b0100;
  localparam logic [3:0] OP_LSR = 4'b0101;
  localparam logic [3:0] OP_ASR = 4'b0110;
  localparam logic [3:0] OP_ADC = 4'b1001;
  localparam logic [3:0] OP_SBC = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_idle;
  logic             w_accept;
  logic             w_single;
  logic             w_load;
  logic [WIDTH-1:0] w_b_op;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [WIDTH-1:0] w_ld_res;
  logic             w_ld_c;
  logic             w_ld_v;
  logic [3:0]       w_ld_flags;

  assign in_ready = reset_n && w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Subtraction is A + ~B + carry, so one adder serves all four arithmetic ops
  always_comb begin
    w_b_op = SrcB;
    w_cin  = 1'b0;
    case (ALUControl)
      OP_ADC: w_cin = CarryIn;
      OP_SUB: begin
        w_b_op = ~SrcB;
        w_cin  = 1'b1;
      end
      OP_SBC: begin
        w_b_op = ~SrcB;
        w_cin  = CarryIn;
      end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, SrcA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (SrcA[WIDTH-1] == w_b_op[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
  assign w_sh  = SrcB[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALUControl)
      OP_AND: w_res = SrcA & SrcB;
      OP_OR:  w_res = SrcA | SrcB;
      OP_XOR: w_res = SrcA ^ SrcB;
      OP_LSL: w_res = SrcA << w_sh;
      OP_LSR: w_res = SrcA >> w_sh;
      OP_ASR: w_res = $unsigned($signed(SrcA) >>> w_sh);
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_mul_start;
  logic             w_mul_done;

  assign w_idle      = (r_state == S_IDLE);
  assign w_mul_start = w_accept && (ALUControl == OP_MUL);
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == '0);
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_single    = w_accept && (ALUControl != OP_MUL);
  assign busy        = (r_state == S_MUL);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Counter runs down from WIDTH-1; the edge that sees zero handles the top bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= SrcA;
      r_mplier <= SrcB;
      r_acc    <= '0;
      r_cnt    <= SHW'(WIDTH - 1);
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - SHW'(1);
    end
  end

  assign w_ld_res = w_mul_done ? w_acc_nxt : w_res;
  assign w_ld_c   = w_mul_done ? 1'b0 : w_c;
  assign w_ld_v   = w_mul_done ? 1'b0 : w_v;
  assign w_load   = w_single || w_mul_done;
`else
  assign w_idle   = 1'b1;
  assign w_single = w_accept;
  assign busy     = 1'b0;
  assign w_ld_res = w_res;
  assign w_ld_c   = w_c;
  assign w_ld_v   = w_v;
  assign w_load   = w_single;
`endif

  assign w_ld_flags = {w_ld_res[WIDTH-1], (w_ld_res == '0), w_ld_c, w_ld_v};

  // A new result wins over the consumer's take on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_ld_res;
      r_flags     <= w_ld_flags;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign ALUFlags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=32; MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        CarryIn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .CarryIn    (CarryIn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    CarryIn    = cin;
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic [3:0] f);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, 64'(ALUResult), 64'(r));
    chk({tag, "_flags"}, 64'(ALUFlags), 64'(f));
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f);
    int  cycles;
    logic saw_idle;
    logic saw_ready;
    drive(4'b0111, a, b, 1'b0);
    step();
    in_valid  = 1'b0;
    cycles    = 0;
    saw_idle  = 1'b0;
    saw_ready = 1'b0;
    while (!out_valid && cycles < 40) begin
      if (!busy) saw_idle = 1'b1;
      if (in_ready) saw_ready = 1'b1;
      step();
      cycles++;
    end
    chk({tag, "_latency"}, 64'(cycles), 64'd32);
    chk({tag, "_busy_gap"}, 64'(saw_idle), 64'd0);
    chk({tag, "_ready_during"}, 64'(saw_ready), 64'd0);
    check_out(tag, r, f);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0011, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001};
    vecs[1]  = '{4'b1011, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0110};
    vecs[2]  = '{4'b1010, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b1000};
    vecs[3]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
    vecs[4]  = '{4'b0011, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0111};
    vecs[5]  = '{4'b1011, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0011};
    vecs[6]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 4'b1000};
    vecs[7]  = '{4'b0001, 32'h0000000F, 32'h000000F0, 1'b0, 32'h000000FF, 4'b0000};
    vecs[8]  = '{4'b0010, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 4'b0100};
    vecs[9]  = '{4'b0100, 32'h00000001, 32'h0000001F, 1'b0, 32'h80000000, 4'b1000};
    vecs[10] = '{4'b0101, 32'h80000000, 32'h00000021, 1'b0, 32'h40000000, 4'b0000};
    vecs[11] = '{4'b0110, 32'h80000000, 32'h00000024, 1'b0, 32'hF8000000, 4'b1000};
    vecs[12] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b0100};
    vecs[13] = '{4'b1000, 32'h00000003, 32'h00000004, 1'b0, 32'h00000000, 4'b0100};
    vecs[14] = '{4'b0011, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 4'b0000};
    vecs[15] = '{4'b1011, 32'h00000003, 32'h00000001, 1'b0, 32'h00000002, 4'b0010};
    vecs[16] = '{4'b1010, 32'h00000003, 32'h00000001, 1'b0, 32'h00000001, 4'b0010};

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    ALUControl = 4'b0000;
    SrcA       = '0;
    SrcB       = '0;
    CarryIn    = 1'b0;
    out_ready  = 1'b1;

    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(ALUResult), 64'd0);
    chk("rst_flags", 64'(ALUFlags), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_low", 64'(in_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready_high", 64'(in_ready), 64'd1);

    // Back-to-back single-cycle ops at full rate
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].f);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_hold", 64'(ALUResult), 64'h00000001);

    // Output stall: ASR result must hold while the consumer is not ready
    out_ready = 1'b0;
    drive(4'b0110, 32'h80000000, 32'h00000024, 1'b0);
    step();
    drive(4'b0011, 32'h00000001, 32'h00000001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_out($sformatf("stall%0d", i), 32'hF8000000, 4'b1000);
      chk($sformatf("stall%0d_ready", i), 64'(in_ready), 64'd0);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(in_ready), 64'd1);
    step();
    check_out("overwrite", 32'h00000002, 4'b0000);
    in_valid = 1'b0;
    step();

`ifdef ALU_SEQ_MUL_EN
    run_mul("mul1", 32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000);
    run_mul("mul2", 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b1000);
    step();

    // Reset at multiply cycle 10 must discard the partial product
    drive(4'b0111, 32'h00010003, 32'h00000005, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    step();
`else
    drive(4'b0111, 32'h00010003, 32'h00000005, 1'b0);
    step();
    in_valid = 1'b0;
    check_out("mul_undef", 32'h00000000, 4'b0100);
    chk("mul_undef_busy", 64'(busy), 64'd0);
    chk("mul_undef_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b0;
    step();
`endif
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_res", 64'(ALUResult), 64'd0);
    chk("rst2_flags", 64'(ALUFlags), 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst2_ready", 64'(in_ready), 64'd1);
    begin
      logic stale;
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (out_valid || busy) stale = 1'b1;
      end
      chk("rst2_no_stale", 64'(stale), 64'd0);
    end
    drive(4'b0011, 32'h00000002, 32'h00000003, 1'b0);
    step();
    in_valid = 1'b0;
    check_out("post_rst_add", 32'h00000005, 4'b0000);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
